// File: rtl/mem_access.sv
// Memory-access pipeline stage: ALU pass-through, plus loads/stores over a
// req/gnt/rvalid port with lane alignment, load extension and a watchdog.
module mem_access #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] alu_out_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        valid_o,
  output logic [31:0] alu_out_o,
  output logic [31:0] rdatamem_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic             req_q;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [1:0]       off_q;
  logic [2:0]       funct3_q;
  logic [31:0]      alu_q;
  logic [3:0]       be_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  logic        is_mem;
  logic        f3_bad;
  logic        align_bad;
  logic        illegal;
  logic        accept;
  logic        timeout_hit;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] sel;
  logic [31:0] ext;

  // Access legality: width/alignment, unsupported funct3, and read+write together
  always_comb begin
    is_mem = mem_read_i | mem_write_i;
    if (mem_write_i)
      f3_bad = (funct3_i >= 3'b011);
    else
      f3_bad = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11);
    case (funct3_i[1:0])
      2'b01:   align_bad = alu_out_i[0];
      2'b10:   align_bad = (alu_out_i[1:0] != 2'b00);
      default: align_bad = 1'b0;
    endcase
    illegal = (mem_read_i & mem_write_i) | f3_bad | align_bad;
    accept  = (state_q == S_IDLE) && valid_i && is_mem && !illegal;
  end

  always_comb begin
    case (funct3_i[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << alu_out_i[1:0];
        wdata_calc = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_calc    = alu_out_i[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{wdata_i[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = wdata_i;
      end
    endcase
  end

  always_comb begin
    sel = dmem_rdata_i >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  ext = {{24{sel[7]}}, sel[7:0]};
      3'b100:  ext = {24'h0, sel[7:0]};
      3'b001:  ext = {{16{sel[15]}}, sel[15:0]};
      3'b101:  ext = {16'h0, sel[15:0]};
      default: ext = dmem_rdata_i;
    endcase
  end

  assign timeout_hit = (cnt_q == TMO_LAST);

  always_comb begin
    state_d    = state_q;
    stall_o    = 1'b0;
    valid_o    = 1'b0;
    misalign_o = 1'b0;
    alu_out_o  = alu_out_i;
    rdatamem_o = 32'h0;
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          if (!is_mem) begin
            valid_o = 1'b1;
          end else if (illegal) begin
            misalign_o = 1'b1;
          end else begin
            stall_o = 1'b1;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        stall_o = 1'b1;
        if (dmem_gnt_i)
          state_d = we_q ? S_DONE : S_RESP;
        else if (timeout_hit)
          state_d = S_DONE;
      end
      S_RESP: begin
        stall_o = 1'b1;
        if (dmem_rvalid_i || timeout_hit)
          state_d = S_DONE;
      end
      S_DONE: begin
        // A timed-out access retires as a bubble; rdata_q is still zero then
        valid_o    = !err_q;
        alu_out_o  = alu_q;
        rdatamem_o = rdata_q;
        state_d    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      off_q    <= 2'b00;
      funct3_q <= 3'b000;
      alu_q    <= 32'h0;
      be_q     <= 4'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            req_q    <= 1'b1;
            we_q     <= mem_write_i;
            addr_q   <= {alu_out_i[31:2], 2'b00};
            off_q    <= alu_out_i[1:0];
            funct3_q <= funct3_i;
            alu_q    <= alu_out_i;
            be_q     <= be_calc;
            wdata_q  <= mem_write_i ? wdata_calc : 32'h0;
            rdata_q  <= 32'h0;
            cnt_q    <= '0;
          end
        end
        S_REQ: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (dmem_gnt_i || timeout_hit) begin
            req_q <= 1'b0;
            we_q  <= 1'b0;
            be_q  <= 4'h0;
          end
          if (!dmem_gnt_i && timeout_hit)
            err_q <= 1'b1;
        end
        S_RESP: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (dmem_rvalid_i)
            rdata_q <= ext;
          else if (timeout_hit)
            err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus_err_o    = err_q;
  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: directed ops push expected bus requests and
// results; a monitor pops and compares whenever the DUT presents them.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0, mem_read_i = 1'b0, mem_write_i = 1'b0;
  logic [2:0]  funct3_i = 3'b000;
  logic [31:0] alu_out_i = 32'h0, wdata_i = 32'h0;
  logic        stall_o, valid_o, misalign_o, bus_err_o;
  logic [31:0] alu_out_o, rdatamem_o;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i = 1'b0;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i = 32'h0;

  logic        rv_auto = 1'b0, rv_force = 1'b0;
  assign dmem_rvalid_i = rv_auto | rv_force;

  // second instance, short watchdog, bus never answers
  logic        t_valid_i = 1'b0;
  logic        t_stall_o, t_valid_o, t_misalign_o, t_bus_err_o;
  logic [31:0] t_alu_out_o, t_rdatamem_o;
  logic        t_dmem_req_o, t_dmem_we_o;
  logic [31:0] t_dmem_addr_o, t_dmem_wdata_o;
  logic [3:0]  t_dmem_be_o;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .funct3_i(funct3_i), .alu_out_i(alu_out_i),
    .wdata_i(wdata_i), .stall_o(stall_o), .valid_o(valid_o), .alu_out_o(alu_out_o),
    .rdatamem_o(rdatamem_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i)
  );

  mem_access #(.TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst), .valid_i(t_valid_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .funct3_i(funct3_i), .alu_out_i(alu_out_i),
    .wdata_i(wdata_i), .stall_o(t_stall_o), .valid_o(t_valid_o), .alu_out_o(t_alu_out_o),
    .rdatamem_o(t_rdatamem_o), .misalign_o(t_misalign_o), .bus_err_o(t_bus_err_o),
    .dmem_req_o(t_dmem_req_o), .dmem_we_o(t_dmem_we_o), .dmem_addr_o(t_dmem_addr_o),
    .dmem_be_o(t_dmem_be_o), .dmem_wdata_o(t_dmem_wdata_o), .dmem_gnt_i(1'b0),
    .dmem_rvalid_i(1'b0), .dmem_rdata_i(32'h0)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  flags;   // {valid_o, misalign_o, bus_err_o}
    logic [31:0] alu;
    logic [31:0] rdat;
    int          cyc;
  } res_t;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;
  res_t res_q[$];
  req_t req_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic   req_prev = 1'b0;
  req_t   held;
  int     run = 0;
  int     last_run = 0;

  initial forever begin
    res_t r;
    req_t q;
    @(negedge clk);
    if (valid_o || misalign_o || bus_err_o) begin
      if (res_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_output: flags=%b alu=0x%08h rdata=0x%08h expected none",
                 {valid_o, misalign_o, bus_err_o}, alu_out_o, rdatamem_o);
      end else begin
        r = res_q.pop_front();
        chk("out_flags", {29'h0, valid_o, misalign_o, bus_err_o}, {29'h0, r.flags});
        chk("out_cycle", cyc, r.cyc);
        if (r.flags == 3'b100) begin
          chk("out_alu", alu_out_o, r.alu);
          chk("out_rdata", rdatamem_o, r.rdat);
        end
      end
    end
    if (dmem_req_o && !req_prev) begin
      if (req_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_req: addr=0x%08h we=%b expected no request", dmem_addr_o, dmem_we_o);
      end else begin
        q = req_q.pop_front();
        chk("req_we", {31'h0, dmem_we_o}, {31'h0, q.we});
        chk("req_addr", dmem_addr_o, q.addr);
        chk("req_be", {28'h0, dmem_be_o}, {28'h0, q.be});
        chk("req_wdata", dmem_wdata_o, q.wdata);
      end
      held.we = dmem_we_o; held.addr = dmem_addr_o; held.be = dmem_be_o; held.wdata = dmem_wdata_o;
      run = 1;
    end else if (dmem_req_o) begin
      run++;
      checks++;
      if ({dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o} !== {held.we, held.addr, held.be, held.wdata}) begin
        failures++;
        $display("FAIL req_stable: addr=0x%08h be=%b wdata=0x%08h expected addr=0x%08h be=%b wdata=0x%08h",
                 dmem_addr_o, dmem_be_o, dmem_wdata_o, held.addr, held.be, held.wdata);
      end
    end else if (req_prev) begin
      last_run = run;
    end
    req_prev = dmem_req_o;
  end

  // ---------------- memory responder ----------------
  int          gnt_dly = 0, rv_dly = 0;
  bit          rv_block = 1'b0;
  logic [31:0] resp_rdata = 32'h0;

  initial begin
    int req_cnt = 0, rv_cnt = 0;
    bit rv_pending = 1'b0;
    forever begin
      @(posedge clk); #1;
      dmem_gnt_i   = 1'b0;
      rv_auto      = 1'b0;
      dmem_rdata_i = 32'h5A5A_5A5A;
      if (rv_pending) begin
        if (rv_cnt == 0) begin
          rv_auto = 1'b1; dmem_rdata_i = resp_rdata; rv_pending = 1'b0;
        end else rv_cnt--;
      end
      if (dmem_req_o) begin
        if (req_cnt == gnt_dly) begin
          dmem_gnt_i = 1'b1; req_cnt = 0;
          if (!dmem_we_o && !rv_block) begin rv_pending = 1'b1; rv_cnt = rv_dly; end
        end else req_cnt++;
      end else req_cnt = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic op(input logic rd, input logic wr, input logic [2:0] f3,
                    input logic [31:0] addr, input logic [31:0] wd);
    valid_i = 1'b1; mem_read_i = rd; mem_write_i = wr; funct3_i = f3;
    alu_out_i = addr; wdata_i = wd;
  endtask

  task automatic idle_in();
    valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && res_q.size() != 0; i++) tick();
    chk("drain_pending", res_q.size(), 0);
  endtask

  task automatic alu_op(input logic [31:0] a);
    res_t rs;
    rs.flags = 3'b100; rs.alu = a; rs.rdat = 32'h0; rs.cyc = cyc;
    res_q.push_back(rs);
    op(1'b0, 1'b0, 3'b000, a, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("alu_stall", {31'h0, stall_o}, 32'h0);
    tick(); idle_in();
    @(negedge clk);
    chk("alu_no_req", {31'h0, dmem_req_o}, 32'h0);
    tick(); drain();
  endtask

  task automatic do_op(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rdat, input logic [3:0] be,
                       input logic [31:0] exp_wd, input logic [31:0] exp_rd, input int lat);
    req_t rq;
    res_t rs;
    rq.we = wr; rq.addr = {addr[31:2], 2'b00}; rq.be = be; rq.wdata = exp_wd;
    req_q.push_back(rq);
    rs.flags = 3'b100; rs.alu = addr; rs.rdat = exp_rd; rs.cyc = cyc + lat;
    res_q.push_back(rs);
    resp_rdata = rdat;
    op(!wr, wr, f3, addr, wd);
    @(negedge clk);
    chk("stall_accept", {31'h0, stall_o}, 32'h1);
    tick(); idle_in();
    @(negedge clk);
    chk("stall_req", {31'h0, stall_o}, 32'h1);
    drain();
  endtask

  task automatic bad_op(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] addr);
    res_t rs;
    rs.flags = 3'b010; rs.alu = addr; rs.rdat = 32'h0; rs.cyc = cyc;
    res_q.push_back(rs);
    op(rd, wr, f3, addr, 32'h1234_5678);
    @(negedge clk);
    chk("bad_stall", {31'h0, stall_o}, 32'h0);
    tick(); idle_in();
    @(negedge clk);
    chk("bad_no_req", {31'h0, dmem_req_o}, 32'h0);
    chk("bad_pulse_len", {31'h0, misalign_o}, 32'h0);
    tick(); drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    int n, t_req, err_cyc, err_cnt;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_stall", {31'h0, stall_o}, 32'h0);
    chk("rst_valid", {31'h0, valid_o}, 32'h0);
    chk("rst_req", {31'h0, dmem_req_o}, 32'h0);
    chk("rst_we_be", {27'h0, dmem_we_o, dmem_be_o}, 32'h0);
    chk("rst_pulses", {30'h0, misalign_o, bus_err_o}, 32'h0);
    tick();

    alu_op(32'h0000_1234);

    do_op(1'b1, 3'b000, 32'h103, 32'h1234_56AB, 32'h0, 4'b1000, 32'hABAB_ABAB, 32'h0, 2);
    do_op(1'b0, 3'b001, 32'h102, 32'h0, 32'h80F0_0000, 4'b1100, 32'h0, 32'hFFFF_80F0, 3);
    do_op(1'b0, 3'b101, 32'h102, 32'h0, 32'h80F0_0000, 4'b1100, 32'h0, 32'h0000_80F0, 3);
    do_op(1'b0, 3'b000, 32'h102, 32'h0, 32'h80F0_0000, 4'b0100, 32'h0, 32'hFFFF_FFF0, 3);
    do_op(1'b0, 3'b100, 32'h101, 32'h0, 32'h1234_C5AA, 4'b0010, 32'h0, 32'h0000_00C5, 3);

    gnt_dly = 3; rv_dly = 2;
    do_op(1'b0, 3'b010, 32'h4, 32'h0, 32'hDEAD_BEEF, 4'b1111, 32'h0, 32'hDEAD_BEEF, 8);
    chk("lw_req_held_cycles", last_run, 4);
    gnt_dly = 0; rv_dly = 0;

    // back-to-back stores: second issued in the IDLE cycle right after DONE
    do_op(1'b1, 3'b001, 32'h2, 32'h1234_ABCD, 32'h0, 4'b1100, 32'hABCD_ABCD, 32'h0, 2);
    do_op(1'b1, 3'b010, 32'h8, 32'hCAFE_F00D, 32'h0, 4'b1111, 32'hCAFE_F00D, 32'h0, 2);

    bad_op(1'b1, 1'b0, 3'b010, 32'h6);
    bad_op(1'b1, 1'b0, 3'b011, 32'h0);
    bad_op(1'b0, 1'b1, 3'b001, 32'h1);
    bad_op(1'b0, 1'b1, 3'b100, 32'h0);
    bad_op(1'b1, 1'b1, 3'b000, 32'h0);
    bad_op(1'b1, 1'b0, 3'b101, 32'h3);

    // reset while waiting in RESP, then a stray rvalid
    begin
      req_t rq;
      rq.we = 1'b0; rq.addr = 32'h8; rq.be = 4'b1111; rq.wdata = 32'h0;
      req_q.push_back(rq);
    end
    rv_block = 1'b1; resp_rdata = 32'h1111_1111;
    op(1'b1, 1'b0, 3'b010, 32'h8, 32'h0);
    tick(); idle_in();
    tick();
    @(negedge clk);
    chk("resp_stall", {31'h0, stall_o}, 32'h1);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; rv_force = 1'b1;
    @(negedge clk);
    chk("post_rst_req", {31'h0, dmem_req_o}, 32'h0);
    chk("post_rst_stall", {31'h0, stall_o}, 32'h0);
    chk("post_rst_valid", {31'h0, valid_o}, 32'h0);
    tick(); rv_force = 1'b0;
    @(negedge clk);
    chk("late_rvalid_valid", {31'h0, valid_o}, 32'h0);
    chk("late_rvalid_stall", {31'h0, stall_o}, 32'h0);
    tick(); rv_block = 1'b0;
    alu_op(32'h0000_55AA);

    // watchdog instance: gnt never arrives
    n = cyc; t_req = 0; err_cyc = -1; err_cnt = 0;
    op(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
    valid_i = 1'b0; t_valid_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (t_dmem_req_o) t_req++;
      if (t_bus_err_o) begin
        err_cnt++;
        if (err_cyc < 0) begin
          err_cyc = cyc;
          chk("to_valid", {31'h0, t_valid_o}, 32'h0);
          chk("to_rdata", t_rdatamem_o, 32'h0);
          chk("to_req_dropped", {31'h0, t_dmem_req_o}, 32'h0);
        end
      end
      tick();
      if (i == 0) begin t_valid_i = 1'b0; idle_in(); end
    end
    chk("to_err_cycle", err_cyc, n + 5);
    chk("to_err_pulses", err_cnt, 1);
    chk("to_req_cycles", t_req, 4);
    @(negedge clk);
    chk("to_idle_stall", {31'h0, t_stall_o}, 32'h0);
    tick();

    chk("req_queue_empty", req_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
